// File: rtl/seg_scan_reader_if.sv
// Display-bus bundle for the seven-segment readback block: the scanned pins in,
// the committed frame, its binary score and the sticky error flag out.
interface seg_scan_reader_if;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [3:0]  digit3;
    logic [3:0]  digit2;
    logic [3:0]  digit1;
    logic [3:0]  digit0;
    logic [13:0] score_bin;
    logic        frame_valid;
    logic        err;

    modport master (
        output seg, an,
        input  digit3, digit2, digit1, digit0, score_bin, frame_valid, err
    );

    modport slave (
        input  seg, an,
        output digit3, digit2, digit1, digit0, score_bin, frame_valid, err
    );
endinterface

// File: rtl/seg_scan_reader.sv
// Multiplexed seven-segment readback: filters each scan slot for stability, decodes it to
// BCD, and publishes a four-digit frame plus its binary score once every slot is captured.
module seg_scan_reader #(
    parameter int unsigned STABLE_CYC = 4
) (
    input logic              clk,
    input logic              rst,
    seg_scan_reader_if.slave bus
);
    localparam logic [15:0] StableCnt  = 16'(STABLE_CYC);
    localparam logic [11:0] IdleSample = {8'hFF, 4'hF};

    logic [11:0] sample;
    logic [11:0] s_now_q;
    logic [15:0] cnt_q, cnt_d;
    logic        changed, capture, commit, bad_digit;
    logic [3:0]  an_low, code;
    logic [13:0] sum;
    logic [3:0]  slot_q [4];
    logic [3:0]  slot_d [4];
    logic [3:0]  dig_q [4];
    logic [3:0]  dig_d [4];
    logic [3:0]  flag_q, flag_d;
    logic        commit_q;
    logic        valid_q, valid_d;
    logic [13:0] score_q, score_d;
    logic        err_q, err_d;

    // Argument is the lit-segment mask {a,b,c,d,e,f,g}, active high.
    function automatic logic [3:0] decode_seg(input logic [6:0] on);
        case (on)
            7'b1111110: decode_seg = 4'd0;
            7'b0110000: decode_seg = 4'd1;
            7'b1101101: decode_seg = 4'd2;
            7'b1111001: decode_seg = 4'd3;
            7'b0110011: decode_seg = 4'd4;
            7'b1011011: decode_seg = 4'd5;
            7'b1011111, 7'b0011111: decode_seg = 4'd6;
            7'b1110000, 7'b1110010: decode_seg = 4'd7;
            7'b1111111: decode_seg = 4'd8;
            7'b1111011, 7'b1110011: decode_seg = 4'd9;
            default:    decode_seg = 4'hF;
        endcase
    endfunction

    always_comb begin
        sample = {bus.seg, bus.an};
        // s_now_q holds the previous sample at the moment the new one is compared.
        changed = (sample != s_now_q);
        if (changed)                  cnt_d = '0;
        else if (cnt_q == StableCnt)  cnt_d = cnt_q;
        else                          cnt_d = cnt_q + 16'd1;
        capture = !changed && (cnt_q == StableCnt - 16'd1);
        an_low  = ~s_now_q[3:0];
        code    = decode_seg(~s_now_q[11:5]);
        commit  = (flag_q == 4'hF);

        slot_d = slot_q;
        dig_d  = dig_q;
        flag_d = flag_q;
        err_d  = err_q;
        if (commit) begin
            dig_d  = slot_q;
            flag_d = '0;
        end
        // Applied after the commit clear so a capture on the commit edge counts next frame.
        if (capture) begin
            if ($onehot(an_low)) begin
                for (int i = 0; i < 4; i++) begin
                    if (an_low[i]) begin
                        slot_d[i] = code;
                        flag_d[i] = 1'b1;
                    end
                end
                if (code == 4'hF) err_d = 1'b1;
            end else if (an_low != 4'h0) begin
                err_d = 1'b1;
            end
        end

        bad_digit = (dig_q[3] == 4'hF) || (dig_q[2] == 4'hF) ||
                    (dig_q[1] == 4'hF) || (dig_q[0] == 4'hF);
        sum = 14'(dig_q[3]) * 14'd1000 + 14'(dig_q[2]) * 14'd100 +
              14'(dig_q[1]) * 14'd10 + 14'(dig_q[0]);
        valid_d = commit_q;
        score_d = score_q;
        if (commit_q) score_d = bad_digit ? 14'h3FFF : sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_now_q  <= IdleSample;
            cnt_q    <= '0;
            slot_q   <= '{default: 4'h0};
            dig_q    <= '{default: 4'h0};
            flag_q   <= '0;
            commit_q <= 1'b0;
            valid_q  <= 1'b0;
            score_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            s_now_q  <= sample;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            dig_q    <= dig_d;
            flag_q   <= flag_d;
            commit_q <= commit;
            valid_q  <= valid_d;
            score_q  <= score_d;
            err_q    <= err_d;
        end
    end

    assign bus.digit3      = dig_q[3];
    assign bus.digit2      = dig_q[2];
    assign bus.digit1      = dig_q[1];
    assign bus.digit0      = dig_q[0];
    assign bus.score_bin   = score_q;
    assign bus.frame_valid = valid_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_seg_scan_reader.sv
// Bench for seg_scan_reader: directed scenarios plus randomized scans, each cycle compared
// against a run-length / slot-table model of the display reader.
module tb_seg_scan_reader;
    localparam int unsigned S = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_reader_if bus ();

    seg_scan_reader #(.STABLE_CYC(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Lit-segment masks {a..g}; alternate forms of 6, 7, 9 at the end.
    logic [6:0] pat_tab [13];
    int         val_tab [13];

    logic [11:0] m_last;
    int          m_run;
    logic [3:0]  m_slot [4];
    logic [3:0]  m_dig [4];
    logic [3:0]  m_flag;
    logic [13:0] m_score;
    logic        m_valid, m_err, m_commit, m_spend;
    int          n_pass, n_total, n_fv;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    function automatic logic [3:0] ref_decode(input logic [6:0] on);
        for (int i = 0; i < 13; i++) if (pat_tab[i] == on) return 4'(val_tab[i]);
        return 4'hF;
    endfunction

    function automatic logic [13:0] frame_value();
        int v = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_dig[i] == 4'hF) return 14'h3FFF;
            v += int'(m_dig[i]) * ((i == 3) ? 1000 : (i == 2) ? 100 : (i == 1) ? 10 : 1);
        end
        return 14'(v);
    endfunction

    task automatic model_reset();
        m_last = {8'hFF, 4'hF};
        m_run = 1;
        for (int i = 0; i < 4; i++) begin
            m_slot[i] = 4'h0;
            m_dig[i] = 4'h0;
        end
        m_flag = 4'h0;
        m_score = '0;
        m_valid = 1'b0;
        m_err = 1'b0;
        m_commit = 1'b0;
        m_spend = 1'b0;
    endtask

    task automatic model_edge(input logic [11:0] smp);
        logic [3:0] low;
        logic [3:0] d;
        if (smp == m_last) begin
            if (m_run < 1000000) m_run++;
        end else begin
            m_run = 1;
        end
        m_last = smp;
        m_valid = m_spend;
        if (m_spend) m_score = frame_value();
        m_spend = 1'b0;
        if (m_commit) begin
            m_dig = m_slot;
            m_flag = 4'h0;
            m_spend = 1'b1;
            m_commit = 1'b0;
        end
        if (m_run == int'(S) + 1) begin
            low = ~smp[3:0];
            if ($countones(low) == 1) begin
                d = ref_decode(~smp[11:5]);
                for (int i = 0; i < 4; i++) begin
                    if (low[i]) begin
                        m_slot[i] = d;
                        m_flag[i] = 1'b1;
                    end
                end
                if (d == 4'hF) m_err = 1'b1;
            end else if ($countones(low) >= 2) begin
                m_err = 1'b1;
            end
        end
        if (m_flag == 4'hF) m_commit = 1'b1;
    endtask

    task automatic tick(input logic [7:0] seg, input logic [3:0] an);
        bus.seg = seg;
        bus.an  = an;
        @(posedge clk);
        model_edge({seg, an});
        @(negedge clk);
        if (bus.frame_valid === 1'b1) n_fv++;
        chk("frame_valid", bus.frame_valid, m_valid);
        chk("err", bus.err, m_err);
        chk("digit3", bus.digit3, m_dig[3]);
        chk("digit2", bus.digit2, m_dig[2]);
        chk("digit1", bus.digit1, m_dig[1]);
        chk("digit0", bus.digit0, m_dig[0]);
        chk("score_bin", bus.score_bin, m_score);
    endtask

    task automatic step(input logic [6:0] on, input logic [3:0] an, input int n);
        for (int i = 0; i < n; i++) tick({~on, 1'b1}, an);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_digits", {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, 16'h0);
        chk("rst_score", bus.score_bin, 14'h0);
        chk("rst_valid", bus.frame_valid, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_fv = 0;
    endtask

    initial begin
        logic [3:0] an;
        logic [6:0] on;
        n_pass = 0;
        n_total = 0;
        n_fv = 0;
        pat_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
                    7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b0011111, 7'b1110010,
                    7'b1110011};
        val_tab = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 6, 7, 9};
        rst = 1'b1;
        bus.seg = 8'hFF;
        bus.an = 4'hF;
        model_reset();
        do_reset();

        // Basic frame 1234.
        step(pat_tab[1], 4'b0111, 10);
        step(pat_tab[2], 4'b1011, 10);
        step(pat_tab[3], 4'b1101, 10);
        step(pat_tab[4], 4'b1110, 10);
        chk("basic_score", bus.score_bin, 14'd1234);
        chk("basic_frames", n_fv, 1);

        // Short "8" pulse on the units slot must not replace the captured 5.
        step(pat_tab[5], 4'b1110, 10);
        step(pat_tab[8], 4'b1110, int'(S));
        step(pat_tab[6], 4'b0111, 10);
        step(pat_tab[7], 4'b1011, 10);
        step(pat_tab[0], 4'b1101, 10);
        step(7'h00, 4'hF, 5);
        chk("glitch_units", bus.digit0, 4'd5);
        chk("glitch_score", bus.score_bin, 14'd6705);

        // Undecodable pattern (only segment a) on the tens slot.
        do_reset();
        step(pat_tab[1], 4'b0111, 10);
        step(7'b1000000, 4'b1101, 10);
        step(pat_tab[2], 4'b1011, 10);
        step(pat_tab[3], 4'b1110, 10);
        chk("bad_digit1", bus.digit1, 4'hF);
        chk("bad_err", bus.err, 1'b1);
        chk("bad_score", bus.score_bin, 14'h3FFF);
        chk("bad_frames", n_fv, 1);

        // Blank anode is harmless; two low anodes flag an error without a frame.
        do_reset();
        step(pat_tab[8], 4'hF, 10);
        chk("blank_err", bus.err, 1'b0);
        step(pat_tab[8], 4'b1100, 10);
        chk("multi_an_err", bus.err, 1'b1);
        chk("multi_an_frames", n_fv, 0);

        // Reset discards a partial frame.
        do_reset();
        step(pat_tab[1], 4'b0111, 10);
        step(pat_tab[2], 4'b1011, 10);
        step(pat_tab[3], 4'b1101, 10);
        do_reset();
        for (int k = 0; k < 4; k++) step(pat_tab[9], ~(4'b0001 << k), 10);
        step(7'h00, 4'hF, 4);
        chk("nines_score", bus.score_bin, 14'd9999);
        chk("nines_frames", n_fv, 1);

        // Randomized scanning with occasional blanks, bad anodes and junk patterns.
        for (int k = 0; k < 300; k++) begin
            if (k % 60 == 0) do_reset();
            case ($urandom_range(0, 19))
                0:       an = 4'hF;
                1:       an = ~(4'b0011 << $urandom_range(0, 2));
                default: an = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 9) == 0) on = 7'($urandom());
            else on = pat_tab[$urandom_range(0, 12)];
            step(on, an, int'($urandom_range(1, 12)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
